// File: rtl/arm_pkg.sv
// Shared definitions for the fetch stage: word width, default reset PC,
// the halt word and the fetch FSM state encoding.
package arm_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // A fetched word equal to this value stops fetching when halt detection is built in.
  localparam logic [WORD_W-1:0] HALT_WORD = 32'h0000_0000;

  // Fetch FSM states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Force an address onto a word boundary.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: DEPTH entries of {pc, instr}. Pointers carry one extra bit
// so full and empty are told apart. Clear has priority over push and pop.
module fetch_queue
  import arm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WORD_W-1:0]       push_pc,
  input  logic [WORD_W-1:0]       push_instr,
  input  logic                    pop,
  input  logic                    clear,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    head_valid,
  output logic [WORD_W-1:0]       head_pc,
  output logic [WORD_W-1:0]       head_instr
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [2*WORD_W-1:0]   entries [DEPTH];
  logic [2*WORD_W-1:0]   head_entry;
  logic                  full;
  logic                  empty;
  logic                  do_push;
  logic                  do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer update; clear empties the queue in one edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage write.
  // NOTE: storage is not reset; the head is gated by empty so stale contents never escape.
  always_ff @(posedge clk1) begin
    if (do_push) entries[wr_ptr[AW-1:0]] <= {push_pc, push_instr};
  end

  // Head presentation; zero when empty so outputs match their reset values.
  assign head_entry = entries[rd_ptr[AW-1:0]];
  assign head_valid = !empty;
  assign head_pc    = empty ? '0 : head_entry[2*WORD_W-1:WORD_W];
  assign head_instr = empty ? '0 : head_entry[WORD_W-1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory, buffers returned words in fetch_queue and hands them
// to decode over valid/ready. A flush empties the queue and redirects.
// Optional feature macro: FETCH_HALT_DETECT_EN (stop fetching on a zero word).
module fetch_unit
  import arm_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_pc,
  output logic              halted
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] fetch_pc_nxt;
  logic [WORD_W-1:0] drain_pc;
  logic [AW:0]       q_count;
  logic [AW:0]       cnt_after;
  logic              ack;
  logic              pop;
  logic              push;
  logic              discard;
  logic              has_space;
  logic              halt_hit;

  // Handshake decode. A word acked during a flush or while draining is dropped.
  assign ack       = mem_req && mem_ack;
  assign pop       = if_valid && if_ready && !flush;
  assign discard   = flush || (state == ST_DRAIN);
  assign push      = ack && !discard;
  assign cnt_after = q_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign has_space = (cnt_after < (AW+1)'(DEPTH));

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = push && (mem_rdata == HALT_WORD);
  assign halted   = (state == ST_HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // Request outputs: while draining, the abandoned address is held until acked.
  assign mem_req  = (state == ST_REQ) || (state == ST_DRAIN);
  assign mem_addr = (state == ST_DRAIN) ? drain_pc : fetch_pc;

  // Next-state and next-PC selection.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      ST_IDLE: begin
        if (flush) begin
          fetch_pc_nxt = word_align(flush_pc);
          state_nxt    = ST_REQ;
        end else if (has_space) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush) begin
          fetch_pc_nxt = word_align(flush_pc);
          state_nxt    = mem_ack ? ST_REQ : ST_DRAIN;
        end else if (mem_ack) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          if (halt_hit)        state_nxt = ST_HALT;
          else if (has_space)  state_nxt = ST_REQ;
          else                 state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (flush)   fetch_pc_nxt = word_align(flush_pc);
        if (mem_ack) state_nxt    = ST_REQ;
      end
      ST_HALT: begin
        if (flush) begin
          fetch_pc_nxt = word_align(flush_pc);
          state_nxt    = ST_REQ;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM, fetch PC and held drain address registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fetch_pc <= word_align(RESET_PC);
      drain_pc <= word_align(RESET_PC);
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (state == ST_REQ && flush && !mem_ack) drain_pc <= fetch_pc;
    end
  end

  // Prefetch queue between memory and decode.
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .push       (push),
    .push_pc    (fetch_pc),
    .push_instr (mem_rdata),
    .pop        (pop),
    .clear      (flush),
    .count      (q_count),
    .head_valid (if_valid),
    .head_pc    (if_pc),
    .head_instr (if_instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (DEPTH=4, RESET_PC=0).
// The memory model returns addr+100, or 0 at zero_addr.
module tb_fetch_unit;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        halted;
  logic [31:0] zero_addr;

  int checks = 0;
  int errors = 0;
  int acks;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .halted    (halted)
  );

  always #5 clk1 = ~clk1;

  // Memory data: updated mid-cycle from the stable request address.
  initial begin
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk1);
      mem_rdata = (mem_addr == zero_addr) ? 32'h0 : mem_addr + 32'd100;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'h0, mem_req},  32'h0);
    check({tag, "_addr"},  mem_addr,          32'h0);
    check({tag, "_valid"}, {31'h0, if_valid}, 32'h0);
    check({tag, "_instr"}, if_instr,          32'h0);
    check({tag, "_pc"},    if_pc,             32'h0);
    check({tag, "_halt"},  {31'h0, halted},   32'h0);
  endtask

  // Hold reset for two edges, then release mid-cycle; next edge is edge 1.
  task automatic reset_dut();
    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    if_ready  = 1'b0;
    flush     = 1'b0;
    flush_pc  = 32'h0;
    zero_addr = 32'hFFFF_FFF0;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    if_ready  = 1'b0;
    flush     = 1'b0;
    flush_pc  = 32'h0;
    zero_addr = 32'hFFFF_FFF0;
    #12;
    check_reset_outputs("rst");

    // Streaming: one word per cycle, first instruction one cycle after first request.
    reset_dut();
    mem_ack  = 1'b1;
    if_ready = 1'b1;
    tick();
    check("s_req1",   {31'h0, mem_req},  32'h1);
    check("s_addr1",  mem_addr,          32'h0);
    check("s_valid1", {31'h0, if_valid}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("s_valid", {31'h0, if_valid}, 32'h1);
      check("s_pc",    if_pc,             32'(4 * i));
      check("s_instr", if_instr,          32'(4 * i + 100));
    end

    // Back-pressure: exactly DEPTH acks, then request drops; resumes after first pop.
    reset_dut();
    mem_ack = 1'b1;
    acks    = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_req && mem_ack) acks++;
    end
    check("bp_acks",  32'(acks),         32'd4);
    check("bp_req0",  {31'h0, mem_req},  32'h0);
    check("bp_head",  if_pc,             32'h0);
    if_ready = 1'b1;
    tick();
    check("bp_req1",  {31'h0, mem_req},  32'h1);
    check("bp_pc1",   if_pc,             32'h4);
    for (int j = 2; j < 6; j++) begin
      tick();
      check("bp_pc",    if_pc,    32'(4 * j));
      check("bp_instr", if_instr, 32'(4 * j + 100));
    end

    // Flush during a delayed ack: address held, word dropped, restart at 0x40.
    reset_dut();
    if_ready = 1'b1;
    tick();
    tick();
    flush    = 1'b1;
    flush_pc = 32'h40;
    tick();
    flush = 1'b0;
    check("dr_req",    {31'h0, mem_req},  32'h1);
    check("dr_hold",   mem_addr,          32'h0);
    check("dr_valid",  {31'h0, if_valid}, 32'h0);
    tick();
    check("dr_hold2",  mem_addr,          32'h0);
    mem_ack = 1'b1;
    tick();
    check("dr_drop",   {31'h0, if_valid}, 32'h0);
    check("dr_addr",   mem_addr,          32'h40);
    tick();
    check("dr_pc",     if_pc,             32'h40);
    check("dr_instr",  if_instr,          32'h40 + 32'd100);

    // Flush coincident with ack and pop, unaligned target 0x83.
    reset_dut();
    mem_ack  = 1'b1;
    if_ready = 1'b1;
    repeat (3) tick();
    flush    = 1'b1;
    flush_pc = 32'h83;
    tick();
    flush = 1'b0;
    check("fc_valid", {31'h0, if_valid}, 32'h0);
    check("fc_addr",  mem_addr,          32'h80);
    tick();
    check("fc_pc",    if_pc,             32'h80);
    check("fc_instr", if_instr,          32'h80 + 32'd100);

    // Zero word at 0xC: halts when detection is built in, ordinary word otherwise.
    reset_dut();
    mem_ack   = 1'b1;
    if_ready  = 1'b1;
    zero_addr = 32'hC;
    repeat (4) tick();
    check("h_pc8",    if_pc,             32'h8);
    tick();
    check("h_pcC",    if_pc,             32'hC);
    check("h_instrC", if_instr,          32'h0);
`ifdef FETCH_HALT_DETECT_EN
    check("h_halted", {31'h0, halted},   32'h1);
    check("h_req",    {31'h0, mem_req},  32'h0);
    tick();
    check("h_drain",  {31'h0, if_valid}, 32'h0);
    check("h_req2",   {31'h0, mem_req},  32'h0);
`else
    check("h_halted", {31'h0, halted},   32'h0);
    check("h_req",    {31'h0, mem_req},  32'h1);
    tick();
    check("h_pc10",   if_pc,             32'h10);
`endif
    zero_addr = 32'hFFFF_FFF0;
    flush     = 1'b1;
    flush_pc  = 32'h20;
    tick();
    flush = 1'b0;
    check("h_clr",    {31'h0, halted},   32'h0);
    check("h_resume", mem_addr,          32'h20);
    check("h_req3",   {31'h0, mem_req},  32'h1);
    tick();
    check("h_pc20",   if_pc,             32'h20);

    // PC wraps modulo 2^32.
    reset_dut();
    mem_ack  = 1'b1;
    if_ready = 1'b1;
    tick();
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFFE;
    tick();
    flush = 1'b0;
    check("w_addr",   mem_addr,          32'hFFFF_FFFC);
    tick();
    check("w_wrap",   mem_addr,          32'h0);
    check("w_pc",     if_pc,             32'hFFFF_FFFC);

    // Asynchronous reset mid-request with a partly filled queue.
    reset_dut();
    mem_ack = 1'b1;
    repeat (4) tick();
    mem_ack = 1'b0;
    check("ar_req",   {31'h0, mem_req},  32'h1);
    check("ar_valid", {31'h0, if_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("ar");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
